// File: rtl/keycode_cmd_unit.sv
// HID keycode word to queued player commands with frame-paced direction auto-repeat.
// Optional KEYCMD_STATS_EN adds a saturating drop/coalesce counter output.
module keycode_cmd_unit #(
  parameter int unsigned REPEAT_DELAY = 12,
  parameter int unsigned REPEAT_RATE  = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] keycode,
  input  logic        frame_clk,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [3:0]  dir_held,
  output logic [7:0]  last_key
`ifdef KEYCMD_STATS_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_BOMB  = 8'h2C;
  localparam logic [2:0] CMD_BOMB  = 3'd4;

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW   = $clog2(RMAX + 1);

  function automatic logic is_rollover(input logic [7:0] c);
    return (c != 8'h00) && (c <= 8'h03);
  endfunction

  function automatic logic slot_hit(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

  // Returns {valid, code} of the highest-priority held direction.
  function automatic logic [2:0] pick_dir(input logic [3:0] h);
    if (h[0])      return 3'b100;
    else if (h[1]) return 3'b101;
    else if (h[2]) return 3'b110;
    else if (h[3]) return 3'b111;
    else           return 3'b000;
  endfunction

  logic [15:0]   kc_q;
  logic [7:0]    last_key_q;
  logic [4:0]    held, held_prev_q, press;
  logic [2:0]    fs_q;
  logic          tick;
  logic [2:0]    act, prev_act;
  logic          changed;
  logic [CW-1:0] rpt_q, rpt_d;
  logic          rpt_fire, dir_ev;
  logic          bomb_pend_q, bomb_pend_d, dir_pend_q, dir_pend_d;
  logic [1:0]    dir_code_q, dir_code_d;
  logic          bomb_take, dir_take, dir_hold, push, pop, room, dropped, coal;
  logic [2:0]    push_code;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;

  assign held = {slot_hit(kc_q, KEY_BOMB), slot_hit(kc_q, KEY_RIGHT), slot_hit(kc_q, KEY_LEFT),
                 slot_hit(kc_q, KEY_DOWN), slot_hit(kc_q, KEY_UP)};
  assign press    = held & ~held_prev_q;
  assign tick     = fs_q[2] & ~fs_q[1];
  assign act      = pick_dir(held[3:0]);
  assign prev_act = pick_dir(held_prev_q[3:0]);
  assign changed  = act != prev_act;

  // A change of active direction always restarts the delay, even on a tick cycle.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    if (changed) begin
      rpt_d = CW'(REPEAT_DELAY);
    end else if (act[2] && tick) begin
      if (rpt_q == CW'(1)) begin
        rpt_fire = 1'b1;
        rpt_d    = CW'(REPEAT_RATE);
      end else begin
        rpt_d = rpt_q - CW'(1);
      end
    end
  end

  assign dir_ev = (act[2] & press[act[1:0]]) | rpt_fire;

  assign pop       = cmd_valid & cmd_ready;
  assign room      = (cnt_q != (PW+1)'(FIFO_DEPTH)) | pop;
  assign bomb_take = bomb_pend_q;
  assign dir_take  = dir_pend_q & ~bomb_pend_q;
  assign push      = (bomb_take | dir_take) & room;
  assign dropped   = (bomb_take | dir_take) & ~room;
  assign push_code = bomb_take ? CMD_BOMB : {1'b0, dir_code_q};
  assign dir_hold  = dir_pend_q & ~dir_take;
  assign coal      = dir_ev & dir_hold;

  // bomb_pend is always consumed in the cycle after it is set, so only dir can coalesce.
  always_comb begin
    bomb_pend_d = press[4];
    dir_pend_d  = dir_hold | dir_ev;
    dir_code_d  = (dir_ev & ~dir_hold) ? act[1:0] : dir_code_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      kc_q        <= '0;
      last_key_q  <= '0;
      held_prev_q <= '0;
      fs_q        <= '0;
      rpt_q       <= CW'(REPEAT_DELAY);
      bomb_pend_q <= 1'b0;
      dir_pend_q  <= 1'b0;
      dir_code_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      if (!is_rollover(keycode[7:0]) && !is_rollover(keycode[15:8])) begin
        kc_q <= keycode;
        if (keycode[7:0] != 8'h00) last_key_q <= keycode[7:0];
      end
      held_prev_q <= held;
      fs_q        <= {fs_q[1:0], frame_clk};
      rpt_q       <= rpt_d;
      bomb_pend_q <= bomb_pend_d;
      dir_pend_q  <= dir_pend_d;
      dir_code_q  <= dir_code_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= push_code;
  end

  assign cmd_valid = cnt_q != '0;
  assign cmd_code  = cmd_valid ? mem_q[rd_ptr_q] : '0;
  assign dir_held  = held_prev_q[3:0];
  assign last_key  = last_key_q;

`ifdef KEYCMD_STATS_EN
  logic [7:0] drop_q;
  logic [8:0] drop_sum;
  assign drop_sum = {1'b0, drop_q} + 9'(dropped) + 9'(coal);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)             drop_q <= '0;
    else if (drop_sum[8])     drop_q <= '1;
    else                      drop_q <= drop_sum[7:0];
  end
  assign drop_count = drop_q;
`else
  logic unused_stats;
  assign unused_stats = dropped | coal;
`endif

endmodule

// File: tb/tb_keycode_cmd_unit.sv
// Randomized and directed bench for keycode_cmd_unit against a behavioural command model.
module tb_keycode_cmd_unit;
  localparam int unsigned RD = 12;
  localparam int unsigned RR = 4;
  localparam int unsigned FD = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] keycode = '0;
  logic        frame_clk = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [3:0]  dir_held;
  logic [7:0]  last_key;
`ifdef KEYCMD_STATS_EN
  logic [7:0]  drop_count;
`endif

  keycode_cmd_unit #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIFO_DEPTH(FD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .dir_held(dir_held), .last_key(last_key)
`ifdef KEYCMD_STATS_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;
  bit done = 1'b0;
  int cyc = 0;
  int popped[$];
  int pop_cyc[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] keys [5] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C};
  logic [15:0] m_kc = '0;
  bit [4:0]    m_hprev = '0;
  int          m_prev_act = -1;
  int          m_n = 0;
  bit          m_bpend = 0, m_dpend = 0;
  int          m_dcode = 0;
  int          m_q[$];
  logic [7:0]  m_last = '0;
  bit          m_hist[$] = {1'b0, 1'b0, 1'b0};
  int          m_drops = 0;

  function automatic bit [4:0] held_of(input logic [15:0] kc);
    bit [4:0] h = '0;
    for (int k = 0; k < 5; k++) h[k] = (kc[7:0] == keys[k]) || (kc[15:8] == keys[k]);
    return h;
  endfunction

  function automatic int active_of(input bit [4:0] h);
    for (int k = 0; k < 4; k++) if (h[k]) return k;
    return -1;
  endfunction

  function automatic bit is_err(input logic [15:0] kc);
    return (kc[7:0] inside {8'h01, 8'h02, 8'h03}) || (kc[15:8] inside {8'h01, 8'h02, 8'h03});
  endfunction

  always @(posedge Clk or negedge Reset_n) begin : model
    bit [4:0] h;
    int act;
    bit tick, dev, bev, pop, room, bt, dt, bhold, dhold;
    if (!Reset_n) begin
      m_kc = '0; m_hprev = '0; m_prev_act = -1; m_n = 0;
      m_bpend = 0; m_dpend = 0; m_dcode = 0; m_q.delete(); m_last = '0;
      m_hist = {1'b0, 1'b0, 1'b0};
      m_drops = 0;
    end else begin
      h    = held_of(m_kc);
      act  = active_of(h);
      tick = m_hist[0] && !m_hist[1];
      dev  = 0;
      if (act != m_prev_act) m_n = 0;
      else if (act >= 0 && tick) begin
        m_n++;
        if (m_n == RD || (m_n > RD && (m_n - RD) % RR == 0)) dev = 1;
      end
      if (act >= 0 && h[act] && !m_hprev[act]) dev = 1;
      bev  = h[4] && !m_hprev[4];
      pop  = (m_q.size() > 0) && cmd_ready;
      room = (m_q.size() < FD) || pop;
      if (pop) void'(m_q.pop_front());
      bt = m_bpend;
      dt = m_dpend && !m_bpend;
      if (bt || dt) begin
        if (room) m_q.push_back(bt ? 4 : m_dcode);
        else m_drops++;
      end
      bhold = m_bpend && !bt;
      if (bev && bhold) m_drops++;
      m_bpend = bhold || bev;
      dhold = m_dpend && !dt;
      if (dev && dhold) m_drops++;
      else if (dev) m_dcode = act;
      m_dpend = dhold || dev;
      m_hprev = h;
      m_prev_act = act;
      if (!is_err(keycode)) begin
        m_kc = keycode;
        if (keycode[7:0] != 8'h00) m_last = keycode[7:0];
      end
      void'(m_hist.pop_front());
      m_hist.push_back(frame_clk);
    end
  end

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (!done) begin
      chk("cmd_valid", int'(cmd_valid), int'(m_q.size() > 0));
      chk("cmd_code", int'(cmd_code), (m_q.size() > 0) ? m_q[0] : 0);
      chk("dir_held", int'(dir_held), int'(m_hprev[3:0]));
      chk("last_key", int'(last_key), int'(m_last));
`ifdef KEYCMD_STATS_EN
      chk("drop_count", int'(drop_count), (m_drops > 255) ? 255 : m_drops);
`endif
      if (Reset_n && cmd_valid && cmd_ready) begin
        popped.push_back(int'(cmd_code));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic tap(input logic [7:0] code);
    keycode = {8'h00, code};
    cycles(3);
    keycode = '0;
    cycles(3);
  endtask

  function automatic logic [7:0] rand_key();
    int r = $urandom % 10;
    case (r)
      0: return 8'h1A;
      1: return 8'h16;
      2: return 8'h04;
      3: return 8'h07;
      4: return 8'h2C;
      5: return 8'($urandom_range(1, 3));
      6: return 8'($urandom);
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    int t0;
    logic [7:0] seq4 [6];
    int exp4 [4];
    seq4 = '{8'h2C, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C};
    exp4 = '{4, 0, 1, 2};

    cycles(1);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_code", int'(cmd_code), 0);
    chk("reset_held", int'(dir_held), 0);
    chk("reset_last", int'(last_key), 0);
    cycles(2);
    Reset_n = 1'b1;
    cycles(2);

    // single UP press, no frame ticks
    cmd_ready = 1'b1;
    popped.delete(); pop_cyc.delete();
    t0 = cyc;
    keycode = 16'h001A;
    cycles(3);
    keycode = '0;
    cycles(6);
    chk("t1_count", popped.size(), 1);
    if (popped.size() == 1) begin
      chk("t1_code", popped[0], 0);
      chk("t1_latency", pop_cyc[0] - t0, 3);
    end

    // RIGHT held across 24 frames
    popped.delete();
    keycode = 16'h0007;
    cycles(4);
    for (int f = 0; f < 24; f++) begin
      frame_clk = 1'b0;
      cycles(1);
      frame_clk = 1'b1;
      cycles(7);
    end
    cycles(6);
    keycode = '0;
    cycles(4);
    chk("t2_count", popped.size(), 5);
    foreach (popped[i]) chk("t2_code", popped[i], 3);

    // simultaneous BOMB + DOWN
    popped.delete(); pop_cyc.delete();
    keycode = 16'h2C16;
    cycles(8);
    keycode = '0;
    cycles(4);
    chk("t3_count", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("t3_first", popped[0], 4);
      chk("t3_second", popped[1], 1);
      chk("t3_gap", pop_cyc[1] - pop_cyc[0], 1);
    end

    // overflow with consumer stalled
    cmd_ready = 1'b0;
    popped.delete();
    foreach (seq4[i]) tap(seq4[i]);
`ifdef KEYCMD_STATS_EN
    chk("t4_drops", int'(drop_count), 2);
`endif
    cmd_ready = 1'b1;
    cycles(8);
    chk("t4_count", popped.size(), 4);
    if (popped.size() == 4) foreach (exp4[i]) chk("t4_order", popped[i], exp4[i]);

    // rollover keycode is ignored
    popped.delete();
    keycode = 16'h001A;
    cycles(5);
    keycode = 16'h0101;
    cycles(6);
    chk("t5_held", int'(dir_held), 1);
    chk("t5_last", int'(last_key), 8'h1A);
    chk("t5_count", popped.size(), 1);
    keycode = '0;
    cycles(4);

    // reset mid-operation with LEFT held
    cmd_ready = 1'b0;
    tap(8'h2C); tap(8'h1A); tap(8'h16);
    chk("t6_queued", int'(cmd_valid), 1);
    keycode = 16'h0004;
    cycles(1);
    Reset_n = 1'b0;
    #1;
    chk("t6_flush", int'(cmd_valid), 0);
    popped.delete();
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    cmd_ready = 1'b1;
    cycles(8);
    chk("t6_count", popped.size(), 1);
    if (popped.size() == 1) chk("t6_code", popped[0], 2);
    keycode = '0;
    cycles(4);

    // random traffic against the model
    for (int s = 0; s < 200; s++) begin
      int len;
      keycode = {rand_key(), rand_key()};
      len = ($urandom % 4 == 0) ? int'($urandom_range(60, 150)) : int'($urandom_range(1, 20));
      for (int c = 0; c < len; c++) begin
        cmd_ready = ($urandom % 4) != 0;
        frame_clk = ($urandom % 8) != 0;
        cycles(1);
      end
    end
    keycode = '0;
    frame_clk = 1'b1;
    cmd_ready = 1'b1;
    cycles(10);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
